// File: rtl/toplu_yazma_birimi.sv
// Block store unit: writes registers ilk..ilk+sayi-1 to consecutive memory words
// starting at a word-aligned base address, one word per granted cycle.
module toplu_yazma_birimi #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baslat,
    input  logic [ADRES_BIT-1:0] taban_adres,
    input  logic [4:0]           ilk_yazmac,
    input  logic [5:0]           sayi,
    input  logic                 bellek_izin,
    output logic [4:0]           yazmac_adres,
    input  logic [VERI_BIT-1:0]  yazmac_veri,
    output logic [ADRES_BIT-1:0] bellek_adres,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz,
    output logic                 mesgul,
    output logic                 bitti,
    output logic                 hata
);

    typedef enum logic [1:0] {
        BOSTA,
        YAZ,
        BITTI
    } durum_t;

    localparam int unsigned ADIM = VERI_BIT / 8;

    durum_t               durum_q, durum_d;
    logic [5:0]           i_q, i_d;
    logic [ADRES_BIT-1:0] taban_q, taban_d;
    logic [4:0]           ilk_q, ilk_d;
    logic [5:0]           sayi_q, sayi_d;
    logic                 hata_q, hata_d;

    logic [6:0]           toplam;
    logic                 gecersiz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum_q <= BOSTA;
            i_q     <= '0;
            taban_q <= '0;
            ilk_q   <= '0;
            sayi_q  <= '0;
            hata_q  <= 1'b0;
        end else begin
            durum_q <= durum_d;
            i_q     <= i_d;
            taban_q <= taban_d;
            ilk_q   <= ilk_d;
            sayi_q  <= sayi_d;
            hata_q  <= hata_d;
        end
    end

    // Range check is done 7 bits wide so ilk+sayi cannot wrap past 32.
    assign toplam   = {2'b00, ilk_yazmac} + {1'b0, sayi};
    assign gecersiz = (taban_adres[1:0] != 2'b00) || (toplam > 7'd32) || (sayi > 6'd32);

    always_comb begin
        durum_d = durum_q;
        i_d     = i_q;
        taban_d = taban_q;
        ilk_d   = ilk_q;
        sayi_d  = sayi_q;
        hata_d  = hata_q;
        unique case (durum_q)
            BOSTA: begin
                if (baslat) begin
                    taban_d = taban_adres;
                    ilk_d   = ilk_yazmac;
                    sayi_d  = sayi;
                    i_d     = '0;
                    hata_d  = gecersiz;
                    if (gecersiz || (sayi == 6'd0)) begin
                        durum_d = BITTI;
                    end else begin
                        durum_d = YAZ;
                    end
                end
            end
            YAZ: begin
                if (bellek_izin) begin
                    if (i_q == sayi_q - 6'd1) begin
                        durum_d = BITTI;
                    end else begin
                        i_d = i_q + 6'd1;
                    end
                end
            end
            BITTI: begin
                durum_d = BOSTA;
                hata_d  = 1'b0;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_comb begin
        yazmac_adres    = '0;
        bellek_adres    = '0;
        bellek_yaz_veri = '0;
        bellek_yaz      = 1'b0;
        bitti           = 1'b0;
        hata            = 1'b0;
        mesgul          = (durum_q != BOSTA);
        unique case (durum_q)
            YAZ: begin
                yazmac_adres    = ilk_q + i_q[4:0];
                bellek_adres    = taban_q + (ADRES_BIT'(i_q) * ADRES_BIT'(ADIM));
                bellek_yaz_veri = yazmac_veri;
                bellek_yaz      = bellek_izin;
            end
            BITTI: begin
                bitti = 1'b1;
                hata  = hata_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_toplu_yazma_birimi.sv
// Bench for toplu_yazma_birimi: table of directed transfers, randomized transfers
// against a word-list model, and hand sequences for reset abort and busy restart.
module tb_toplu_yazma_birimi;

    logic        clk = 1'b0;
    logic        rst;
    logic        baslat;
    logic [31:0] taban_adres;
    logic [4:0]  ilk_yazmac;
    logic [5:0]  sayi;
    logic        bellek_izin;
    logic [4:0]  yazmac_adres;
    logic [31:0] yazmac_veri;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_yaz_veri;
    logic        bellek_yaz;
    logic        mesgul;
    logic        bitti;
    logic        hata;

    logic [31:0] regs [32];
    assign yazmac_veri = regs[yazmac_adres];

    always #5 clk = ~clk;

    toplu_yazma_birimi #(.ADRES_BIT(32), .VERI_BIT(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .baslat         (baslat),
        .taban_adres    (taban_adres),
        .ilk_yazmac     (ilk_yazmac),
        .sayi           (sayi),
        .bellek_izin    (bellek_izin),
        .yazmac_adres   (yazmac_adres),
        .yazmac_veri    (yazmac_veri),
        .bellek_adres   (bellek_adres),
        .bellek_yaz_veri(bellek_yaz_veri),
        .bellek_yaz     (bellek_yaz),
        .mesgul         (mesgul),
        .bitti          (bitti),
        .hata           (hata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", ad, gercek, beklenen);
        end
    endtask

    typedef struct {
        logic [31:0] taban;
        logic [4:0]  ilk;
        logic [5:0]  sayi;
        int          lo;
        int          hi;
        bit          poke;
        bit          e_hata;
        int          e_bitti;
        int          e_yaz;
        string       ad;
    } vek_t;

    task automatic rastgele_regs();
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
    endtask

    // Drives one transfer; cycle c is the interval after acceptance edge c-1.
    task automatic calistir(input vek_t v);
        int          n_yaz;
        int          bcyc;
        logic        hgor;
        logic [31:0] beklenen_adr;
        logic [31:0] r;
        int          idx;
        rastgele_regs();
        @(posedge clk); #1;
        baslat      = 1'b1;
        taban_adres = v.taban;
        ilk_yazmac  = v.ilk;
        sayi        = v.sayi;
        bellek_izin = 1'b1;
        @(posedge clk); #1;
        baslat      = 1'b0;
        r = $urandom; taban_adres = r;
        r = $urandom; ilk_yazmac  = r[4:0];
        sayi        = r[10:5];
        n_yaz = 0;
        bcyc  = -1;
        hgor  = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            bellek_izin = (c >= v.lo && c <= v.hi) ? 1'b0 : 1'b1;
            baslat      = v.poke && (c == 2);
            @(negedge clk);
            beklenen_adr = v.taban + 32'(4 * n_yaz);
            if (bellek_yaz) begin
                if (n_yaz < v.e_yaz) begin
                    idx = int'(v.ilk) + n_yaz;
                    chk({v.ad, " adres"}, bellek_adres, beklenen_adr);
                    chk({v.ad, " veri"}, bellek_yaz_veri, regs[idx]);
                end
                n_yaz++;
            end else if (mesgul && !bitti) begin
                chk({v.ad, " durma_adres"}, bellek_adres, beklenen_adr);
            end
            if (bitti) begin
                bcyc = c;
                hgor = hata;
            end else begin
                chk({v.ad, " hata_erken"}, hata, 1'b0);
            end
            @(posedge clk); #1;
            baslat = 1'b0;
            if (bcyc >= 0) break;
        end
        chk({v.ad, " yazma_sayisi"}, n_yaz, v.e_yaz);
        chk({v.ad, " bitti_dongu"}, bcyc, v.e_bitti);
        chk({v.ad, " hata"}, hgor, v.e_hata);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({v.ad, " bosta_mesgul"}, {mesgul, bellek_yaz, bitti}, 3'b000);
        end
    endtask

    // Reference model: word count and completion cycle from the transfer rules.
    function automatic vek_t modelle(input logic [31:0] ta, input logic [4:0] ilk, input logic [5:0] n,
                                     input int lo, input int hi, input bit poke);
        vek_t v;
        bit   err;
        int   stall;
        err       = (ta[1:0] != 2'b00) || (int'(ilk) + int'(n) > 32) || (int'(n) > 32);
        v.taban   = ta;
        v.ilk     = ilk;
        v.sayi    = n;
        v.lo      = lo;
        v.hi      = hi;
        v.poke    = poke;
        v.e_hata  = err;
        v.e_yaz   = err ? 0 : int'(n);
        stall     = (lo >= 1 && lo <= v.e_yaz) ? (hi - lo + 1) : 0;
        v.e_bitti = (v.e_yaz == 0) ? 1 : v.e_yaz + 1 + stall;
        v.ad      = "rastgele";
        return v;
    endfunction

    vek_t tablo [9];

    initial begin
        int   nw;
        logic [31:0] r;
        logic [31:0] ta;
        vek_t v;

        tablo[0] = '{32'h8000_1000, 5'd1,  6'd30, 0, 0, 1'b0, 1'b0, 31, 30, "tam"};
        tablo[1] = '{32'h8000_1000, 5'd1,  6'd30, 3, 5, 1'b0, 1'b0, 34, 30, "durma"};
        tablo[2] = '{32'h8000_2000, 5'd20, 6'd13, 0, 0, 1'b0, 1'b1, 1,  0,  "sinir_asim"};
        tablo[3] = '{32'h0000_0400, 5'd0,  6'd32, 0, 0, 1'b0, 1'b0, 33, 32, "sinir_32"};
        tablo[4] = '{32'h8000_1000, 5'd5,  6'd0,  0, 0, 1'b0, 1'b0, 1,  0,  "bos"};
        tablo[5] = '{32'h8000_1002, 5'd1,  6'd4,  0, 0, 1'b0, 1'b1, 1,  0,  "hizasiz"};
        tablo[6] = '{32'hFFFF_FFFC, 5'd3,  6'd2,  0, 0, 1'b0, 1'b0, 3,  2,  "sarma"};
        tablo[7] = '{32'h0000_0000, 5'd0,  6'd40, 0, 0, 1'b0, 1'b1, 1,  0,  "sayi_buyuk"};
        tablo[8] = '{32'h1234_5678, 5'd0,  6'd6,  2, 2, 1'b1, 1'b0, 8,  6,  "mesgul_baslat"};

        rst         = 1'b0;
        baslat      = 1'b0;
        taban_adres = '0;
        ilk_yazmac  = '0;
        sayi        = '0;
        bellek_izin = 1'b0;
        rastgele_regs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cikislar", {bellek_adres, bellek_yaz_veri, yazmac_adres, bellek_yaz, mesgul, bitti, hata}, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (tablo[k]) calistir(tablo[k]);

        // Wrapped address is checked explicitly in addition to the per-word model.
        @(posedge clk); #1;
        baslat = 1'b1; taban_adres = 32'hFFFF_FFFC; ilk_yazmac = 5'd7; sayi = 6'd2; bellek_izin = 1'b1;
        @(posedge clk); #1; baslat = 1'b0;
        @(posedge clk); #1;
        chk("sarma_ikinci_adres", bellek_adres, 32'h0000_0000);
        chk("sarma_ikinci_yazmac", yazmac_adres, 5'd8);
        repeat (3) @(posedge clk);

        for (int t = 0; t < 20; t++) begin
            r  = $urandom;
            ta = {r[31:2], 2'b00};
            if (r[1:0] == 2'b11 && r[5]) ta[0] = 1'b1;
            r  = $urandom;
            v  = modelle(ta, r[4:0], 6'($urandom_range(0, 40)), $urandom_range(1, 12), 0, r[8]);
            v.hi = v.lo + int'($urandom_range(0, 3));
            v = modelle(v.taban, v.ilk, v.sayi, v.lo, v.hi, v.poke);
            calistir(v);
        end

        // Abort after five granted writes; reset must clear outputs without a clock edge.
        rastgele_regs();
        @(posedge clk); #1;
        baslat = 1'b1; taban_adres = 32'h1000_0000; ilk_yazmac = 5'd2; sayi = 6'd10; bellek_izin = 1'b1;
        @(posedge clk); #1; baslat = 1'b0;
        nw = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bellek_yaz) nw++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("reset_ortasi_cikislar", {bellek_adres, bellek_yaz_veri, yazmac_adres, bellek_yaz, mesgul, bitti, hata}, '0);
        chk("reset_oncesi_yazma", nw, 5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_bitti_yok", {bitti, hata, bellek_yaz}, 3'b000);
        end
        @(posedge clk); #1;
        rst = 1'b1; baslat = 1'b1; taban_adres = 32'h0000_0040; ilk_yazmac = 5'd4; sayi = 6'd1;
        @(posedge clk); #1; baslat = 1'b0;
        @(negedge clk);
        chk("reset_sonrasi_kabul", {mesgul, bellek_yaz}, 2'b11);
        chk("reset_sonrasi_adres", bellek_adres, 32'h0000_0040);
        chk("reset_sonrasi_veri", bellek_yaz_veri, regs[4]);
        @(negedge clk);
        chk("reset_sonrasi_bitti", {bitti, hata}, 2'b10);
        @(negedge clk);
        chk("reset_sonrasi_bosta", mesgul, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL zaman_asimi actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/toplu_yazma_birimi.md
TOPLU_YAZMA_BIRIMI -- requirements
Module: toplu_yazma_birimi

Interface
REQ-001 SHALL have parameter ADRES_BIT, default 32, memory address width.
REQ-002 SHALL have parameter VERI_BIT, default 32, memory/register data width; word stride is VERI_BIT/8 bytes.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have baslat  input  1  start request, sampled only in BOSTA.
REQ-006 SHALL have taban_adres  input  ADRES_BIT  base memory address, captured on accepted baslat.
REQ-007 SHALL have ilk_yazmac  input  5  first register index, captured on accepted baslat.
REQ-008 SHALL have sayi  input  6  number of registers to store (0..32), captured on accepted baslat.
REQ-009 SHALL have bellek_izin  input  1  memory grant; a write issues only in a cycle where it is 1.
REQ-010 SHALL have yazmac_adres  output  5  register-file read index.
REQ-011 SHALL have yazmac_veri  input  VERI_BIT  register-file read data, combinational from yazmac_adres.
REQ-012 SHALL have bellek_adres  output  ADRES_BIT  memory word address.
REQ-013 SHALL have bellek_yaz_veri  output  VERI_BIT  memory write data.
REQ-014 SHALL have bellek_yaz  output  1  memory write strobe, one word per asserted cycle.
REQ-015 SHALL have mesgul  output  1  high in every state except BOSTA.
REQ-016 SHALL have bitti  output  1  one-cycle completion pulse.
REQ-017 SHALL have hata  output  1  one-cycle error pulse, coincident with bitti.

Function
REQ-018 SHALL implement states BOSTA, YAZ, BITTI.
REQ-019 In BOSTA with baslat=1, SHALL capture taban_adres/ilk_yazmac/sayi, clear index i to 0, and move to YAZ next edge, unless an error or empty case applies.
REQ-020 Error case: taban_adres[1:0]!=0, or ilk_yazmac+sayi>32, or sayi>32: SHALL go to BITTI with no writes and assert hata in BITTI.
REQ-021 Empty case: sayi=0 and no error: SHALL go directly to BITTI with no writes and hata=0.
REQ-022 In YAZ, yazmac_adres SHALL be ilk_yazmac+i, bellek_adres SHALL be taban_adres+4*i (modulo 2^ADRES_BIT), bellek_yaz_veri SHALL be yazmac_veri, and bellek_yaz SHALL equal bellek_izin.
REQ-023 In YAZ, i SHALL increment only when bellek_izin=1; with bellek_izin=0 all outputs hold and nothing is written.
REQ-024 After the write with i=sayi-1 is granted, SHALL move to BITTI next edge.
REQ-025 In BITTI, bitti=1 for exactly one cycle, then return to BOSTA.
REQ-026 Latency with bellek_izin held at 1: baslat accepted at edge 0; writes at cycles 1..N; bitti high in cycle N+1; mesgul low from cycle N+2.
REQ-027 baslat while mesgul=1 SHALL be ignored and not queued.
REQ-028 Captured parameters SHALL NOT change after acceptance, even if the inputs change.
REQ-029 In BOSTA and BITTI, bellek_yaz=0, bellek_adres=0, bellek_yaz_veri=0, yazmac_adres=0.
REQ-030 Register index 0 SHALL be stored like any other (value as read).

Reset
REQ-031 rst=0 SHALL immediately force BOSTA, i=0, captured parameters=0, and all outputs to 0, independent of clk.
REQ-032 Reset during YAZ SHALL abort the transfer; words already written remain; no bitti/hata pulse is produced.
REQ-033 After rst rises, the first baslat SHALL be accepted on the next rising edge.

Verification
REQ-034 Full store: regs x1..x30 random, taban=0x8000_1000, ilk=1, sayi=30, izin=1 -> 30 writes; mem[0x8000_1000+4k]=x(k+1) for k=0..29; bitti at cycle 31; hata=0.
REQ-035 Stall: same as REQ-034 with bellek_izin=0 on cycles 3-5 -> bellek_adres holds 0x8000_1008 through the stall; no duplicate or skipped word; bitti at cycle 34.
REQ-036 Bounds: ilk=20, sayi=13 -> zero writes; bitti=hata=1 in cycle 1; ilk=0, sayi=32 -> 32 writes, hata=0.
REQ-037 Edge cases: sayi=0 -> bitti at cycle 1, no writes; taban=0x8000_1002 -> hata with no writes; taban=0xFFFF_FFFC, sayi=2 -> second address is 0x0000_0000.
REQ-038 Reset and busy: rst=0 mid-YAZ after 5 writes -> outputs 0 immediately, exactly 5 words written, no bitti; baslat pulsed while mesgul=1 -> ignored, a single transfer only.
